// File: rtl/branch_resolve_pipe.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_pipe
// Brief    : Two-stage RV32 B-type branch resolution (decode/register, then
//            compare/target) with valid/ready on both sides and a saturating
//            taken counter. Optional macro BRANCH_PREDICT_EN adds a static
//            BTFN mispredict flag.
// Revision : 1.0
// ============================================================================
module branch_resolve_pipe #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      instr,
  input  logic [PC_W-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       rs1_idx,
  output logic [4:0]       rs2_idx,
  output logic             taken,
  output logic [PC_W-1:0]  next_pc,
  output logic             illegal,
  output logic             misaligned,
  output logic             mispredict,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int c_imm_w = 13;

  logic [c_imm_w-1:0] w_imm13;
  logic [PC_W-1:0]    w_imm;
  logic               w_s2_adv;
  logic               w_accept;
  logic               w_s2_load;
  logic               w_retire;

  logic               r_s1_valid;
  logic [PC_W-1:0]    r_s1_pc;
  logic [PC_W-1:0]    r_s1_imm;
  logic [2:0]         r_s1_func3;
  logic [4:0]         r_s1_rs1_idx;
  logic [4:0]         r_s1_rs2_idx;
  logic [XLEN-1:0]    r_s1_a;
  logic [XLEN-1:0]    r_s1_b;

  logic               r_out_valid;
  logic [4:0]         r_rs1_idx;
  logic [4:0]         r_rs2_idx;
  logic               r_taken;
  logic [PC_W-1:0]    r_next_pc;
  logic               r_illegal;
  logic               r_misaligned;
  logic [CNT_W-1:0]   r_taken_cnt;

  logic [PC_W-1:0]    w_target;
  logic [PC_W-1:0]    w_seq_pc;
  logic               w_cond;
  logic               w_illegal;
  logic               w_taken;
  logic [PC_W-1:0]    w_next_pc;
  logic               w_misaligned;

  assign w_imm13   = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm     = {{(PC_W-c_imm_w){w_imm13[c_imm_w-1]}}, w_imm13};

  assign w_s2_adv  = !r_out_valid || out_ready;
  assign in_ready  = !rst && (!r_s1_valid || w_s2_adv);
  // flush wins over both accept and retirement
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_s2_load = r_s1_valid && w_s2_adv && !flush;
  assign w_retire  = r_out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_pc      <= '0;
      r_s1_imm     <= '0;
      r_s1_func3   <= '0;
      r_s1_rs1_idx <= '0;
      r_s1_rs2_idx <= '0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
    end else if (flush) begin
      r_s1_valid   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid   <= 1'b1;
      r_s1_pc      <= pc;
      r_s1_imm     <= w_imm;
      r_s1_func3   <= instr[14:12];
      r_s1_rs1_idx <= instr[19:15];
      r_s1_rs2_idx <= instr[24:20];
      r_s1_a       <= rs1_data;
      r_s1_b       <= rs2_data;
    end else if (w_s2_adv) begin
      r_s1_valid   <= 1'b0;
    end
  end

  always_comb begin
    w_cond    = 1'b0;
    w_target  = r_s1_pc + r_s1_imm;
    w_seq_pc  = r_s1_pc + {{(PC_W-3){1'b0}}, 3'd4};
    w_illegal = (r_s1_func3[2:1] == 2'b01);
    case (r_s1_func3)
      3'b000:  w_cond = (r_s1_a == r_s1_b);
      3'b001:  w_cond = (r_s1_a != r_s1_b);
      3'b100:  w_cond = ($signed(r_s1_a) <  $signed(r_s1_b));
      3'b101:  w_cond = ($signed(r_s1_a) >= $signed(r_s1_b));
      3'b110:  w_cond = (r_s1_a <  r_s1_b);
      3'b111:  w_cond = (r_s1_a >= r_s1_b);
      default: w_cond = 1'b0;
    endcase
    w_taken      = w_cond && !w_illegal;
    w_next_pc    = w_taken ? w_target : w_seq_pc;
    w_misaligned = w_taken && w_target[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_rs1_idx    <= '0;
      r_rs2_idx    <= '0;
      r_taken      <= 1'b0;
      r_next_pc    <= '0;
      r_illegal    <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid  <= r_s1_valid;
      if (r_s1_valid) begin
        r_rs1_idx    <= r_s1_rs1_idx;
        r_rs2_idx    <= r_s1_rs2_idx;
        r_taken      <= w_taken;
        r_next_pc    <= w_next_pc;
        r_illegal    <= w_illegal;
        r_misaligned <= w_misaligned;
      end
    end
  end

  // counter sticks at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt <= '0;
    end else if (w_retire && r_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
      r_taken_cnt <= r_taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef BRANCH_PREDICT_EN
  logic r_mispredict;
  logic w_mispredict;

  // BTFN: backward (negative immediate) branches are predicted taken
  assign w_mispredict = (w_taken != r_s1_imm[PC_W-1]) && !w_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mispredict <= 1'b0;
    end else if (w_s2_load) begin
      r_mispredict <= w_mispredict;
    end
  end

  assign mispredict = r_out_valid && r_mispredict;
`else
  assign mispredict = 1'b0;
`endif

  assign out_valid  = r_out_valid;
  assign rs1_idx    = r_rs1_idx;
  assign rs2_idx    = r_rs2_idx;
  assign taken      = r_taken;
  assign next_pc    = r_next_pc;
  assign illegal    = r_illegal;
  assign misaligned = r_misaligned;
  assign taken_cnt  = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_pipe
// Brief    : Directed self-checking bench for branch_resolve_pipe (CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_branch_resolve_pipe;

  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:7]      instr;
  logic [PC_W-1:0]  pc;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       rs1_idx;
  logic [4:0]       rs2_idx;
  logic             taken;
  logic [PC_W-1:0]  next_pc;
  logic             illegal;
  logic             misaligned;
  logic             mispredict;
  logic [CNT_W-1:0] taken_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  branch_resolve_pipe #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .taken      (taken),
    .next_pc    (next_pc),
    .illegal    (illegal),
    .misaligned (misaligned),
    .mispredict (mispredict),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:7] mk(input logic [2:0] f3, input logic [12:0] imm,
                                     input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] t;
    t        = '0;
    t[31]    = imm[12];
    t[7]     = imm[11];
    t[30:25] = imm[10:5];
    t[11:8]  = imm[4:1];
    t[14:12] = f3;
    t[19:15] = r1;
    t[24:20] = r2;
    return t[31:7];
  endfunction

  function automatic logic exp_mp(input logic mp);
`ifdef BRANCH_PREDICT_EN
    return mp;
`else
    return 1'b0 & mp;
`endif
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [12:0] imm,
                       input logic [31:0] p, input logic [31:0] ra, input logic [31:0] rb);
    instr    = mk(f3, imm, 5'd9, 5'd22);
    pc       = p;
    rs1_data = ra;
    rs2_data = rb;
    in_valid = 1'b1;
  endtask

  // one isolated beat: accept, check latency, check result, check counter
  task automatic vec(input string tag, input logic [2:0] f3, input logic [12:0] imm,
                     input logic [31:0] p, input logic [31:0] ra, input logic [31:0] rb,
                     input logic et, input logic [31:0] enpc, input logic eill,
                     input logic emis, input logic emp);
    @(negedge clk);
    out_ready = 1'b1;
    drive(f3, imm, p, ra, rb);
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_taken"}, taken, et);
    chk({tag, "_next_pc"}, next_pc, enpc);
    chk({tag, "_illegal"}, illegal, eill);
    chk({tag, "_misaligned"}, misaligned, emis);
    chk({tag, "_mispredict"}, mispredict, exp_mp(emp));
    chk({tag, "_rs1_idx"}, rs1_idx, 9);
    chk({tag, "_rs2_idx"}, rs2_idx, 22);
    if (et && exp_cnt < 3) exp_cnt++;
    @(negedge clk);
    #1;
    chk({tag, "_cnt"}, taken_cnt, exp_cnt);
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    int  sent;
    int  recv;
    logic acc;
    logic ret;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_next_pc", next_pc, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    chk("rst_taken", taken, 0);
    chk("rst_mispredict", mispredict, 0);
    rst = 1'b0;
    #1 chk("rel_in_ready", in_ready, 1);

    vec("beq", 3'b000, 13'h0010, 32'h100, 32'd5, 32'd5, 1, 32'h110, 0, 0, 1);

    // flush with both stages full; out_ready high at the flush edge
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'b000, 13'h0010, 32'h700, 32'd1, 32'd1);
    @(negedge clk);
    drive(3'b000, 13'h0010, 32'h710, 32'd1, 32'd1);
    @(negedge clk);
    #1 chk("fl_full", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    drive(3'b000, 13'h0010, 32'h720, 32'd1, 32'd1);
    @(negedge clk);
    #1;
    chk("fl_out_cleared", out_valid, 0);
    chk("fl_cnt", taken_cnt, exp_cnt);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1 chk("fl_no_accept", out_valid, 0);
    @(negedge clk);
    #1 chk("fl_empty", out_valid, 0);

    vec("blt",   3'b100, 13'h0020, 32'h200, 32'hFFFF_FFFF, 32'd1, 1, 32'h220, 0, 0, 1);
    vec("bltu",  3'b110, 13'h0020, 32'h200, 32'hFFFF_FFFF, 32'd1, 0, 32'h204, 0, 0, 0);
    vec("ill2",  3'b010, 13'h0040, 32'h300, 32'd0, 32'd0,          0, 32'h304, 1, 0, 0);
    vec("misal", 3'b001, 13'h0006, 32'h400, 32'd1, 32'd2,          1, 32'h406, 0, 1, 1);
    vec("bgeb",  3'b101, 13'h1FF8, 32'h500, 32'd3, 32'd3,          1, 32'h4F8, 0, 0, 0);
    vec("bgeu",  3'b111, 13'h1FF8, 32'h600, 32'd1, 32'd2,          0, 32'h604, 0, 0, 1);
    vec("fwdnt", 3'b000, 13'h0010, 32'h800, 32'd1, 32'd2,          0, 32'h804, 0, 0, 0);
    vec("wrap",  3'b000, 13'h0008, 32'hFFFF_FFFC, 32'd7, 32'd7,    1, 32'h4,   0, 0, 1);
    vec("bgesn", 3'b101, 13'h0010, 32'h900, 32'h8000_0000, 32'd0,  0, 32'h904, 0, 0, 0);
    vec("ill3",  3'b011, 13'h1FF8, 32'hA00, 32'd4, 32'd4,          0, 32'hA04, 1, 0, 0);

    // backpressure: four back-to-back beats, out_ready low for the first 7 cycles
    sent = 0; recv = 0;
    @(negedge clk);
    drive(3'b000, 13'h0020, 32'h1000, 32'd0, 32'd0);
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      out_ready = (cyc >= 7);
      #1;
      if (cyc == 2) begin
        chk("bp_in_ready_drop", in_ready, 0);
        chk("bp_two_held", sent, 2);
      end
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (out_valid) begin
        chk("bp_next_pc", next_pc, 32'h1020 + 32'(recv) * 32'h10);
        chk("bp_taken", taken, 1);
      end
      if (ret) recv++;
      @(negedge clk);
      if (acc) begin
        sent++;
        if (sent < 4) drive(3'b000, 13'h0020, 32'h1000 + 32'(sent) * 32'h10, 32'(sent), 32'(sent));
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    #1;
    chk("bp_all_delivered", recv, 4);
    chk("bp_no_extra", out_valid, 0);
    chk("bp_cnt_sat", taken_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
